// File: rtl/reg_sb_if.sv
`default_nettype none
// ============================================================================
// reg_sb_if : ID/WB-side signal bundle for the register scoreboard  (rev 1.0)
// ============================================================================
interface reg_sb_if #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 2
);
   logic                  issue_valid;
   logic                  issue_wr;
   logic [AW-1:0]         issue_rd;
   logic [AW-1:0]         rs1_id;
   logic [AW-1:0]         rs2_id;
   logic                  rs1_used;
   logic                  rs2_used;
   logic                  flush;
   logic                  wb_valid;
   logic [AW-1:0]         wb_rd;
   logic                  drain_req;
   logic                  stall;
   logic                  issue_fire;
   logic                  drain_ack;
   logic [NREG-1:0]       busy_vec;
   logic [AW+CNT_W-1:0]   inflight;
   logic                  sb_err;

   modport master (
      output issue_valid, issue_wr, issue_rd, rs1_id, rs2_id, rs1_used, rs2_used,
             flush, wb_valid, wb_rd, drain_req,
      input  stall, issue_fire, drain_ack, busy_vec, inflight, sb_err
   );

   modport slave (
      input  issue_valid, issue_wr, issue_rd, rs1_id, rs2_id, rs1_used, rs2_used,
             flush, wb_valid, wb_rd, drain_req,
      output stall, issue_fire, drain_ack, busy_vec, inflight, sb_err
   );
endinterface
`default_nettype wire

// File: rtl/reg_sb_ctrl.sv
`default_nettype none
// ============================================================================
// reg_sb_ctrl : RAW/overflow scoreboard with drain/halt handshake  (rev 1.0)
// ============================================================================
module reg_sb_ctrl #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 2
) (
   input  wire logic clk,
   input  wire logic rst_n,
   reg_sb_if.slave   sb
);
   localparam int IW = AW + CNT_W;

   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_drain  = 2'd1;
   localparam logic [1:0] c_st_halted = 2'd2;

   logic [1:0]                  state_q, state_d;
   logic                        drain_ack_q;
   logic [NREG-1:0][CNT_W-1:0]  pend_q, pend_d;
   logic [IW-1:0]               inflight_q, inflight_d;
   logic                        sb_err_q, sb_err_d;

   logic w_issue_ok;
   logic w_wb_hit_rs1, w_wb_hit_rs2, w_wb_hit_rd;
   logic w_haz_rs1, w_haz_rs2, w_ovf;
   logic w_stall, w_fire;
   logic w_inc_any, w_dec_any, w_same;
   logic w_inc_cnt, w_dec_cnt, w_dec_zero;

   // ------------------------------------------------------------------------
   // Hazard detection: a single outstanding write retiring this very cycle is
   // visible through the register-file write-through, so it does not stall.
   // ------------------------------------------------------------------------
   assign w_issue_ok   = sb.issue_valid && !sb.flush;
   assign w_wb_hit_rs1 = sb.wb_valid && (sb.wb_rd == sb.rs1_id);
   assign w_wb_hit_rs2 = sb.wb_valid && (sb.wb_rd == sb.rs2_id);
   assign w_wb_hit_rd  = sb.wb_valid && (sb.wb_rd == sb.issue_rd);

   always_comb begin
      w_haz_rs1 = 1'b0;
      w_haz_rs2 = 1'b0;
      w_ovf     = 1'b0;
      if (sb.rs1_used && (sb.rs1_id != '0)) begin
         w_haz_rs1 = (pend_q[sb.rs1_id] > c_cnt_one) ||
                     ((pend_q[sb.rs1_id] == c_cnt_one) && !w_wb_hit_rs1);
      end
      if (sb.rs2_used && (sb.rs2_id != '0)) begin
         w_haz_rs2 = (pend_q[sb.rs2_id] > c_cnt_one) ||
                     ((pend_q[sb.rs2_id] == c_cnt_one) && !w_wb_hit_rs2);
      end
      if (sb.issue_wr && (sb.issue_rd != '0)) begin
         w_ovf = (pend_q[sb.issue_rd] == c_cnt_max) && !w_wb_hit_rd;
      end
   end

   // ------------------------------------------------------------------------
   // Counter bookkeeping. An issue and a retire to the same register cancel,
   // so at most one register increments and a different one decrements.
   // ------------------------------------------------------------------------
   assign w_inc_any  = w_fire && sb.issue_wr && (sb.issue_rd != '0);
   assign w_dec_any  = sb.wb_valid && (sb.wb_rd != '0);
   assign w_same     = w_inc_any && w_dec_any && (sb.issue_rd == sb.wb_rd);
   assign w_inc_cnt  = w_inc_any && !w_same;
   assign w_dec_cnt  = w_dec_any && !w_same && (pend_q[sb.wb_rd] != '0);
   assign w_dec_zero = w_dec_any && !w_same && (pend_q[sb.wb_rd] == '0);

   always_comb begin
      pend_d = pend_q;
      if (w_inc_cnt) begin
         pend_d[sb.issue_rd] = pend_q[sb.issue_rd] + c_cnt_one;
      end
      if (w_dec_cnt) begin
         pend_d[sb.wb_rd] = pend_q[sb.wb_rd] - c_cnt_one;
      end
   end

   assign inflight_d = inflight_q + IW'(w_inc_cnt) - IW'(w_dec_cnt);
   assign sb_err_d   = sb_err_q | w_dec_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         inflight_q <= '0;
         sb_err_q   <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         inflight_q <= inflight_d;
         sb_err_q   <= sb_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Drain FSM: state register / next-state / outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= c_st_idle;
         drain_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_ack_q <= (state_d == c_st_halted);
      end
   end

   // HALTED is entered on the same edge that retires the last pending write.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle: begin
            if (sb.drain_req) state_d = c_st_drain;
         end
         c_st_drain: begin
            if (!sb.drain_req)         state_d = c_st_idle;
            else if (inflight_d == '0) state_d = c_st_halted;
         end
         c_st_halted: begin
            if (!sb.drain_req) state_d = c_st_idle;
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_comb begin
      w_stall = w_issue_ok &&
                (w_haz_rs1 || w_haz_rs2 || w_ovf || (state_q != c_st_idle));
      w_fire  = w_issue_ok && !w_stall;
   end

   assign sb.stall      = w_stall;
   assign sb.issue_fire = w_fire;
   assign sb.drain_ack  = drain_ack_q;
   assign sb.inflight   = inflight_q;
   assign sb.sb_err     = sb_err_q;

   for (genvar r = 0; r < NREG; r++) begin : g_busy
      if (r == 0) begin : g_x0
         assign sb.busy_vec[r] = 1'b0;
      end else begin : g_xn
         assign sb.busy_vec[r] = |pend_q[r];
      end
   end

`ifndef SYNTHESIS
   logic [IW-1:0] w_pend_sum;
   always_comb begin
      w_pend_sum = '0;
      for (int r = 0; r < NREG; r++) begin
         w_pend_sum = w_pend_sum + IW'(pend_q[r]);
      end
   end

   a_inflight_sum: assert property (@(posedge clk) disable iff (!rst_n)
      inflight_q == w_pend_sum);
   a_fire_excl_stall: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_fire && w_stall));
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_sb_ctrl.sv
`default_nettype none
// tb_reg_sb_ctrl: directed scenarios plus randomized traffic against a
// per-register pending-count model of the scoreboard.
module tb_reg_sb_ctrl;
   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 2;
   localparam int IW    = AW + CNT_W;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   string tname = "init";

   reg_sb_if #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W)) sif ();

   reg_sb_ctrl #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sif)
   );

   always #5 clk = ~clk;

   // Reference model: pending writes per register, total, error flag, mode
   // (0 = running, 1 = draining, 2 = halted).
   int m_pend[NREG];
   int m_infl;
   bit m_err;
   int m_mode;
   bit m_ack;
   bit exp_stall, exp_fire;
   logic obs_stall, obs_fire;

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_pend[i] = 0;
      m_infl = 0; m_err = 0; m_mode = 0; m_ack = 0;
   endtask

   function automatic logic [NREG-1:0] exp_busy();
      logic [NREG-1:0] v;
      for (int i = 0; i < NREG; i++) v[i] = (m_pend[i] != 0);
      return v;
   endfunction

   function automatic bit src_blocked(int s, bit used);
      if (!used || s == 0) return 1'b0;
      if (m_pend[s] >= 2) return 1'b1;
      return (m_pend[s] == 1) && !(sif.wb_valid && int'(sif.wb_rd) == s);
   endfunction

   task automatic drive_idle();
      sif.issue_valid = 0; sif.issue_wr = 0; sif.issue_rd = '0;
      sif.rs1_id = '0; sif.rs2_id = '0; sif.rs1_used = 0; sif.rs2_used = 0;
      sif.flush = 0; sif.wb_valid = 0; sif.wb_rd = '0; sif.drain_req = 0;
   endtask

   task automatic set_issue(bit wr, int rd);
      sif.issue_valid = 1; sif.issue_wr = wr; sif.issue_rd = AW'(rd);
   endtask

   task automatic set_wb(bit v, int rd);
      sif.wb_valid = v; sif.wb_rd = AW'(rd);
   endtask

   // One clock: predict same-cycle outputs, sample them, advance the model,
   // and return just after the next falling edge with registered outputs settled.
   task automatic cyc();
      int  rd, wbrd;
      bit  ovf, inc, dec;
      #1;
      rd   = int'(sif.issue_rd);
      wbrd = int'(sif.wb_rd);
      ovf  = sif.issue_wr && rd != 0 && m_pend[rd] == CMAX &&
             !(sif.wb_valid && wbrd == rd);
      exp_stall = sif.issue_valid && !sif.flush &&
                  (src_blocked(int'(sif.rs1_id), sif.rs1_used) ||
                   src_blocked(int'(sif.rs2_id), sif.rs2_used) || ovf || m_mode != 0);
      exp_fire  = sif.issue_valid && !sif.flush && !exp_stall;
      obs_stall = sif.stall;
      obs_fire  = sif.issue_fire;
      inc = exp_fire && sif.issue_wr && rd != 0;
      dec = sif.wb_valid && wbrd != 0;
      if (!(inc && dec && rd == wbrd)) begin
         if (inc) begin m_pend[rd]++; m_infl++; end
         if (dec) begin
            if (m_pend[wbrd] == 0) m_err = 1;
            else begin m_pend[wbrd]--; m_infl--; end
         end
      end
      case (m_mode)
         0: if (sif.drain_req) m_mode = 1;
         1: if (!sif.drain_req) m_mode = 0; else if (m_infl == 0) m_mode = 2;
         default: if (!sif.drain_req) m_mode = 0;
      endcase
      m_ack = (m_mode == 2);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 0;
      drive_idle();
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      tname = "reset";
      drive_idle();
      sif.issue_valid = 1; sif.rs1_id = 5'd5; sif.rs1_used = 1;
      model_reset();
      #2;
      checks++; if (sif.stall !== 1'b0) begin failures++; $display("FAIL reset/stall got=%b want=0", sif.stall); end
      checks++; if (sif.issue_fire !== 1'b1) begin failures++; $display("FAIL reset/fire got=%b want=1", sif.issue_fire); end
      checks++; if (sif.busy_vec !== '0) begin failures++; $display("FAIL reset/busy got=%h want=0", sif.busy_vec); end
      checks++; if (sif.inflight !== '0) begin failures++; $display("FAIL reset/inflight got=%0d want=0", sif.inflight); end
      checks++; if (sif.drain_ack !== 1'b0) begin failures++; $display("FAIL reset/ack got=%b want=0", sif.drain_ack); end
      checks++; if (sif.sb_err !== 1'b0) begin failures++; $display("FAIL reset/err got=%b want=0", sif.sb_err); end
      @(negedge clk);
      rst_n = 1;
      drive_idle();
   endtask

   task automatic test_raw();
      tname = "raw";
      do_reset();
      set_issue(1, 5); cyc();
      checks++; if (obs_fire !== 1'b1) begin failures++; $display("FAIL raw/issue_fire got=%b want=1", obs_fire); end
      checks++; if (sif.busy_vec[5] !== 1'b1) begin failures++; $display("FAIL raw/busy5 got=%b want=1", sif.busy_vec[5]); end
      set_issue(0, 0); sif.rs1_id = 5'd5; sif.rs1_used = 1;
      for (int c = 1; c <= 2; c++) begin
         cyc();
         checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL raw/stall_c%0d got=%b want=1", c, obs_stall); end
      end
      set_wb(1, 5); cyc();
      checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL raw/wb_stall got=%b want=0", obs_stall); end
      checks++; if (obs_fire !== 1'b1) begin failures++; $display("FAIL raw/wb_fire got=%b want=1", obs_fire); end
      checks++; if (sif.busy_vec[5] !== 1'b0) begin failures++; $display("FAIL raw/busy5_clr got=%b want=0", sif.busy_vec[5]); end
      drive_idle();
   endtask

   task automatic test_overflow();
      tname = "ovf";
      do_reset();
      set_issue(1, 7);
      for (int c = 0; c < 3; c++) cyc();
      checks++; if (sif.inflight !== IW'(3)) begin failures++; $display("FAIL ovf/inflight3 got=%0d want=3", sif.inflight); end
      cyc();
      checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL ovf/stall got=%b want=1", obs_stall); end
      checks++; if (obs_fire !== 1'b0) begin failures++; $display("FAIL ovf/nofire got=%b want=0", obs_fire); end
      set_wb(1, 7); cyc();
      checks++; if (obs_fire !== 1'b1) begin failures++; $display("FAIL ovf/wb_fire got=%b want=1", obs_fire); end
      checks++; if (sif.inflight !== IW'(3)) begin failures++; $display("FAIL ovf/hold3 got=%0d want=3", sif.inflight); end
      drive_idle();
   endtask

   task automatic test_zero_err();
      tname = "zero";
      do_reset();
      set_issue(1, 0); sif.rs1_id = '0; sif.rs1_used = 1; sif.rs2_id = '0; sif.rs2_used = 1;
      cyc();
      checks++; if (obs_stall !== 1'b0 || obs_fire !== 1'b1) begin failures++; $display("FAIL zero/x0_issue got=%b%b want=01", obs_stall, obs_fire); end
      checks++; if (sif.inflight !== '0) begin failures++; $display("FAIL zero/inflight got=%0d want=0", sif.inflight); end
      drive_idle(); set_wb(1, 9); cyc();
      checks++; if (sif.sb_err !== 1'b1) begin failures++; $display("FAIL zero/err_set got=%b want=1", sif.sb_err); end
      drive_idle(); cyc(); cyc();
      checks++; if (sif.sb_err !== 1'b1) begin failures++; $display("FAIL zero/err_sticky got=%b want=1", sif.sb_err); end
   endtask

   task automatic test_flush_same();
      tname = "flush";
      do_reset();
      set_issue(1, 3); sif.flush = 1; cyc();
      checks++; if (obs_fire !== 1'b0 || obs_stall !== 1'b0) begin failures++; $display("FAIL flush/fire_stall got=%b%b want=00", obs_fire, obs_stall); end
      checks++; if (sif.busy_vec[3] !== 1'b0) begin failures++; $display("FAIL flush/busy3 got=%b want=0", sif.busy_vec[3]); end
      drive_idle(); set_issue(1, 4); cyc();
      sif.rs1_id = 5'd4; sif.rs1_used = 1; sif.issue_wr = 0; sif.flush = 1; cyc();
      checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL flush/haz_masked got=%b want=0", obs_stall); end
      drive_idle(); set_issue(1, 4); set_wb(1, 4); cyc();
      checks++; if (obs_fire !== 1'b1) begin failures++; $display("FAIL flush/same_fire got=%b want=1", obs_fire); end
      checks++; if (sif.inflight !== IW'(1) || sif.busy_vec[4] !== 1'b1) begin failures++; $display("FAIL flush/same_hold got=%0d/%b want=1/1", sif.inflight, sif.busy_vec[4]); end
      drive_idle();
   endtask

   task automatic test_drain();
      tname = "drain";
      do_reset();
      set_issue(1, 2); cyc();
      set_issue(1, 6); cyc();
      drive_idle(); sif.drain_req = 1; cyc();
      set_issue(1, 8); cyc();
      checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL drain/stall got=%b want=1", obs_stall); end
      set_wb(1, 2); cyc();
      checks++; if (sif.drain_ack !== 1'b0) begin failures++; $display("FAIL drain/early_ack got=%b want=0", sif.drain_ack); end
      set_wb(1, 6); cyc();
      checks++; if (sif.drain_ack !== 1'b1) begin failures++; $display("FAIL drain/ack got=%b want=1", sif.drain_ack); end
      set_wb(0, 0); cyc();
      checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL drain/halt_stall got=%b want=1", obs_stall); end
      drive_idle(); cyc();
      checks++; if (sif.drain_ack !== 1'b0) begin failures++; $display("FAIL drain/ack_drop got=%b want=0", sif.drain_ack); end
      set_issue(1, 8); cyc();
      checks++; if (obs_fire !== 1'b1) begin failures++; $display("FAIL drain/resume got=%b want=1", obs_fire); end
      drive_idle(); sif.drain_req = 1; cyc();
      #2; rst_n = 0; model_reset();
      drive_idle(); sif.issue_valid = 1; sif.rs1_id = 5'd8; sif.rs1_used = 1;
      #1;
      checks++; if (sif.inflight !== '0 || sif.busy_vec !== '0) begin failures++; $display("FAIL drain/rst_clear got=%0d/%h want=0/0", sif.inflight, sif.busy_vec); end
      checks++; if (sif.stall !== 1'b0 || sif.drain_ack !== 1'b0) begin failures++; $display("FAIL drain/rst_idle got=%b%b want=00", sif.stall, sif.drain_ack); end
      @(negedge clk); rst_n = 1;
      cyc();
      checks++; if (obs_fire !== 1'b1) begin failures++; $display("FAIL drain/post_rst got=%b want=1", obs_fire); end
      drive_idle();
   endtask

   task automatic test_random();
      int r;
      tname = "rand";
      do_reset();
      for (int n = 0; n < 600; n++) begin
         sif.issue_valid = ($urandom_range(0, 3) != 0);
         sif.issue_wr    = ($urandom_range(0, 3) != 0);
         sif.issue_rd    = AW'($urandom_range(0, 7));
         sif.rs1_id      = AW'($urandom_range(0, 7));
         sif.rs2_id      = AW'($urandom_range(0, 7));
         sif.rs1_used    = $urandom_range(0, 1);
         sif.rs2_used    = $urandom_range(0, 1);
         sif.flush       = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 7);
         sif.wb_rd       = AW'(r);
         sif.wb_valid    = ($urandom_range(0, 2) != 0) &&
                           (m_pend[r] != 0 || $urandom_range(0, 39) == 0);
         if ($urandom_range(0, 24) == 0) sif.drain_req = !sif.drain_req;
         cyc();
         checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL rand/stall n=%0d got=%b want=%b", n, obs_stall, exp_stall); end
         checks++; if (obs_fire !== exp_fire) begin failures++; $display("FAIL rand/fire n=%0d got=%b want=%b", n, obs_fire, exp_fire); end
         checks++; if (sif.busy_vec !== exp_busy()) begin failures++; $display("FAIL rand/busy n=%0d got=%h want=%h", n, sif.busy_vec, exp_busy()); end
         checks++; if (sif.inflight !== IW'(m_infl)) begin failures++; $display("FAIL rand/inflight n=%0d got=%0d want=%0d", n, sif.inflight, m_infl); end
         checks++; if (sif.drain_ack !== m_ack) begin failures++; $display("FAIL rand/ack n=%0d got=%b want=%b", n, sif.drain_ack, m_ack); end
         checks++; if (sif.sb_err !== m_err) begin failures++; $display("FAIL rand/err n=%0d got=%b want=%b", n, sif.sb_err, m_err); end
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_overflow();
      test_zero_err();
      test_flush_same();
      test_drain();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached in %s", tname);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
